// File: rtl/vector_stepper.sv
// vector_stepper: steps two frequency words along a linear vector, one pixel per handshake.
// Ports: clk, resetq (sync, active-low); cmd_* command handshake (start/inc/amp/count/blank);
// abort; pix_* pixel handshake and payload; busy; pix_count (pixels emitted since reset).
// Option: define VECTOR_STEPPER_BLANK_EN to honour cmd_blank (latch zero amplitudes).
module vector_stepper #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_start0,
  input  logic [31:0]      cmd_start1,
  input  logic [31:0]      cmd_inc0,
  input  logic [31:0]      cmd_inc1,
  input  logic [9:0]       cmd_amp0,
  input  logic [9:0]       cmd_amp1,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_blank,
  input  logic             abort,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [31:0]      pix_freq0,
  output logic [31:0]      pix_freq1,
  output logic [9:0]       pix_amp0,
  output logic [9:0]       pix_amp1,
  output logic             busy,
  output logic [CNT_W-1:0] pix_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [31:0]      pos0;
  logic [31:0]      pos1;
  logic [31:0]      inc0;
  logic [31:0]      inc1;
  logic [9:0]       amp0;
  logic [9:0]       amp1;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] pcnt;

  logic blank_en;
  logic zero_amp;
  logic accept;
  logic hs;

`ifdef VECTOR_STEPPER_BLANK_EN
  assign blank_en = 1'b1;
`else
  assign blank_en = 1'b0;
`endif

  // cmd_blank stays referenced in both builds; it is gated off when disabled
  assign zero_amp  = cmd_blank & blank_en;

  assign cmd_ready = (state == IDLE) & resetq & ~abort;
  assign accept    = cmd_valid & cmd_ready;
  assign pix_valid = (state == RUN);
  assign busy      = (state != IDLE);
  assign hs        = pix_valid & pix_ready;

  assign pix_freq0 = pos0;
  assign pix_freq1 = pos1;
  assign pix_amp0  = amp0;
  assign pix_amp1  = amp1;
  assign pix_count = pcnt;

  always_ff @(posedge clk) begin
    if (!resetq) begin
      state     <= IDLE;
      pos0      <= '0;
      pos1      <= '0;
      inc0      <= '0;
      inc1      <= '0;
      amp0      <= '0;
      amp1      <= '0;
      remaining <= '0;
      pcnt      <= '0;
    end else begin
      // a pixel taken in the abort cycle was really delivered, so count it
      if (hs)
        pcnt <= pcnt + CNT_W'(1);
      if (abort) begin
        state <= IDLE;
      end else if (accept) begin
        pos0      <= cmd_start0;
        pos1      <= cmd_start1;
        inc0      <= cmd_inc0;
        inc1      <= cmd_inc1;
        amp0      <= zero_amp ? 10'd0 : cmd_amp0;
        amp1      <= zero_amp ? 10'd0 : cmd_amp1;
        remaining <= cmd_count;
        state     <= (cmd_count != '0) ? RUN : IDLE;
      end else if (hs) begin
        pos0      <= pos0 + inc0;
        pos1      <= pos1 + inc1;
        remaining <= remaining - CNT_W'(1);
        if (remaining == CNT_W'(1))
          state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_vector_stepper.sv
// tb_vector_stepper: scoreboard bench for vector_stepper.
// Stimulus pushes expected pixels; a negedge monitor pops and compares on handshakes.
module tb_vector_stepper;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             resetq;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_start0;
  logic [31:0]      cmd_start1;
  logic [31:0]      cmd_inc0;
  logic [31:0]      cmd_inc1;
  logic [9:0]       cmd_amp0;
  logic [9:0]       cmd_amp1;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_blank;
  logic             abort;
  logic             pix_valid;
  logic             pix_ready;
  logic [31:0]      pix_freq0;
  logic [31:0]      pix_freq1;
  logic [9:0]       pix_amp0;
  logic [9:0]       pix_amp1;
  logic             busy;
  logic [CNT_W-1:0] pix_count;

  vector_stepper #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .resetq     (resetq),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start0 (cmd_start0),
    .cmd_start1 (cmd_start1),
    .cmd_inc0   (cmd_inc0),
    .cmd_inc1   (cmd_inc1),
    .cmd_amp0   (cmd_amp0),
    .cmd_amp1   (cmd_amp1),
    .cmd_count  (cmd_count),
    .cmd_blank  (cmd_blank),
    .abort      (abort),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_freq0  (pix_freq0),
    .pix_freq1  (pix_freq1),
    .pix_amp0   (pix_amp0),
    .pix_amp1   (pix_amp1),
    .busy       (busy),
    .pix_count  (pix_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] f0;
    logic [31:0] f1;
    logic [9:0]  a0;
    logic [9:0]  a1;
  } pix_t;

  pix_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef VECTOR_STEPPER_BLANK_EN
  localparam logic [9:0] BLANK_AMP = 10'h000;
`else
  localparam logic [9:0] BLANK_AMP = 10'h3FF;
`endif

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] f0, input logic [31:0] f1,
                      input logic [9:0] a0, input logic [9:0] a1);
    pix_t p;
    p.f0 = f0;
    p.f1 = f1;
    p.a0 = a0;
    p.a1 = a1;
    exp_q.push_back(p);
  endtask

  // Monitor: compare every handshake, and hold-stability under stall
  pix_t held;
  logic held_v = 1'b0;
  always @(negedge clk) begin
    pix_t cur;
    pix_t e;
    cur.f0 = pix_freq0;
    cur.f1 = pix_freq1;
    cur.a0 = pix_amp0;
    cur.a1 = pix_amp1;
    if (held_v && resetq && pix_valid)
      check("stall_hold", 64'(cur), 64'(held));
    if (pix_valid && pix_ready && resetq) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pixel: got %0h expected none", cur);
      end else begin
        e = exp_q.pop_front();
        check("pix_f0", 64'(cur.f0), 64'(e.f0));
        check("pix_f1", 64'(cur.f1), 64'(e.f1));
        check("pix_a0", 64'(cur.a0), 64'(e.a0));
        check("pix_a1", 64'(cur.a1), 64'(e.a1));
      end
    end
    held_v = pix_valid & ~pix_ready & resetq & ~abort;
    held   = cur;
  end

  // Offer a command; returns #1 after the accepting edge
  task automatic send(input logic [31:0] s0, input logic [31:0] s1,
                      input logic [31:0] i0, input logic [31:0] i1,
                      input logic [9:0] a0, input logic [9:0] a1,
                      input logic [CNT_W-1:0] cnt, input logic blk);
    bit ok = 0;
    @(posedge clk);
    #1;
    cmd_valid  = 1'b1;
    cmd_start0 = s0;
    cmd_start1 = s1;
    cmd_inc0   = i0;
    cmd_inc1   = i1;
    cmd_amp0   = a0;
    cmd_amp1   = a1;
    cmd_count  = cnt;
    cmd_blank  = blk;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_timeout: got no cmd_ready expected accept");
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
  endtask

  initial begin
    resetq     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_start0 = '0;
    cmd_start1 = '0;
    cmd_inc0   = '0;
    cmd_inc1   = '0;
    cmd_amp0   = '0;
    cmd_amp1   = '0;
    cmd_count  = '0;
    cmd_blank  = 1'b0;
    abort      = 1'b0;
    pix_ready  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(pix_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(pix_count), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    resetq = 1'b1;
    @(negedge clk);
    check("rel_ready", 64'(cmd_ready), 64'd1);

    // Basic vector, one pixel per cycle
    push(32'h1000, 32'h2000, 10'h155, 10'h2AA);
    push(32'h1010, 32'h1FFF, 10'h155, 10'h2AA);
    push(32'h1020, 32'h1FFE, 10'h155, 10'h2AA);
    push(32'h1030, 32'h1FFD, 10'h155, 10'h2AA);
    send(32'h1000, 32'h2000, 32'h10, 32'hFFFF_FFFF,
         10'h155, 10'h2AA, 16'd4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("basic_rate", 64'(pix_valid), 64'd1);
    end
    @(negedge clk);
    check("basic_done_v", 64'(pix_valid), 64'd0);
    check("basic_busy", 64'(busy), 64'd0);
    check("basic_count", 64'(pix_count), 64'd4);

    // Backpressure, pix_ready toggling
    pix_ready = 1'b0;
    push(32'h100, 32'h200, 10'h001, 10'h002);
    push(32'h103, 32'h1FB, 10'h001, 10'h002);
    push(32'h106, 32'h1F6, 10'h001, 10'h002);
    send(32'h100, 32'h200, 32'h3, 32'hFFFF_FFFB,
         10'h001, 10'h002, 16'd3, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (!busy) break;
      pix_ready = ~pix_ready;
      @(posedge clk);
      #1;
    end
    pix_ready = 1'b1;
    wait_idle(10);
    check("bp_count", 64'(pix_count), 64'd7);

    // Wrap-around of the frequency word
    push(32'hFFFF_FFF0, 32'h0, 10'h0AA, 10'h0BB);
    push(32'h0000_0010, 32'h0, 10'h0AA, 10'h0BB);
    send(32'hFFFF_FFF0, 32'h0, 32'h20, 32'h0,
         10'h0AA, 10'h0BB, 16'd2, 1'b0);
    wait_idle(10);
    check("wrap_count", 64'(pix_count), 64'd9);

    // Zero count: no pixel, ready again next cycle
    send(32'h1234, 32'h5678, 32'h1, 32'h1,
         10'h011, 10'h022, 16'd0, 1'b0);
    @(negedge clk);
    check("zero_valid", 64'(pix_valid), 64'd0);
    check("zero_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    check("zero_valid2", 64'(pix_valid), 64'd0);
    check("zero_count", 64'(pix_count), 64'd9);

    // Abort coincident with the 5th handshake
    for (int k = 0; k < 5; k++)
      push(32'(k), 32'h77, 10'h033, 10'h044);
    send(32'h0, 32'h77, 32'h1, 32'h0,
         10'h033, 10'h044, 16'd100, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    check("abort_pre_v", 64'(pix_valid), 64'd1);
    @(posedge clk);
    #1;
    check("abort_valid", 64'(pix_valid), 64'd0);
    check("abort_count", 64'(pix_count), 64'd14);
    cmd_valid = 1'b1;
    cmd_count = 16'd3;
    @(negedge clk);
    check("abort_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    abort     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_no_acc", 64'(busy), 64'd0);
    check("abort_count2", 64'(pix_count), 64'd14);

    // Reset during the 3rd pixel
    push(32'h500, 32'h0, 10'h055, 10'h066);
    push(32'h501, 32'h0, 10'h055, 10'h066);
    send(32'h500, 32'h0, 32'h1, 32'h0,
         10'h055, 10'h066, 16'd10, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    resetq = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_valid", 64'(pix_valid), 64'd0);
    check("mrst_count", 64'(pix_count), 64'd0);
    check("mrst_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    resetq = 1'b1;
    @(negedge clk);
    check("mrst_rel_rdy", 64'(cmd_ready), 64'd1);
    check("mrst_rel_v", 64'(pix_valid), 64'd0);

    // Blank command
    push(32'h42, 32'h43, BLANK_AMP, BLANK_AMP);
    send(32'h42, 32'h43, 32'h1, 32'h1,
         10'h3FF, 10'h3FF, 16'd1, 1'b1);
    wait_idle(10);
    check("blank_count", 64'(pix_count), 64'd1);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
